// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with a double-buffered display word.
// Drives a 2-to-4 digit decoder (sel/sel_en) and the matching nibble to the segment encoder.
module disp_scan_ctrl #(
    parameter int DIV_W = 16,
    parameter int DIV   = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    input  logic [3:0]  blank_mask,
    output logic [1:0]  sel,
    output logic        sel_en,
    output logic [3:0]  digit,
    output logic        frame_start
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             r_state, w_state_nxt;
    logic [DIV_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_sel, w_sel_nxt;
    logic               r_sel_en, w_sel_en_nxt;
    logic               r_frame_start, w_frame_start_nxt;
    logic [15:0]        r_pending;
    logic [15:0]        r_shadow, w_shadow_nxt;
    logic [15:0]        w_load;
    logic               w_tick;

    // A strobe in the same cycle as a shadow load bypasses the pending register.
    assign w_load = data_valid ? data_in : r_pending;
    assign w_tick = (r_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_sel_en      <= 1'b0;
            r_frame_start <= 1'b0;
            r_pending     <= '0;
            r_shadow      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sel         <= w_sel_nxt;
            r_sel_en      <= w_sel_en_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_shadow      <= w_shadow_nxt;
            if (data_valid) begin
                r_pending <= data_in;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = '0;
        w_sel_nxt         = '0;
        w_sel_en_nxt      = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_shadow_nxt      = r_shadow;

        unique case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt       = SCAN;
                    w_shadow_nxt      = w_load;
                    w_frame_start_nxt = 1'b1;
                    w_sel_en_nxt      = ~blank_mask[0];
                end
            end
            SCAN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                end else if (w_tick) begin
                    // blank_mask is only sampled here so a digit never flickers mid-dwell.
                    w_sel_nxt    = r_sel + 2'd1;
                    w_sel_en_nxt = ~blank_mask[w_sel_nxt];
                    if (r_sel == 2'd3) begin
                        w_shadow_nxt      = w_load;
                        w_frame_start_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt    = r_cnt + DIV_W'(1);
                    w_sel_nxt    = r_sel;
                    w_sel_en_nxt = r_sel_en;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign sel         = r_sel;
    assign sel_en      = r_sel_en;
    assign frame_start = r_frame_start;
    assign digit       = r_shadow[4*r_sel +: 4];

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: two instances (DIV=4 and DIV=1) share stimulus;
// a frame-time reference model pushes expected outputs, a monitor pops and compares.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic [3:0]  blank_mask = '0;

    logic [1:0]  sel4, sel1;
    logic        sel_en4, sel_en1;
    logic [3:0]  digit4, digit1;
    logic        fs4, fs1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.DIV_W(16), .DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_valid(data_valid),
        .blank_mask(blank_mask), .sel(sel4), .sel_en(sel_en4), .digit(digit4),
        .frame_start(fs4)
    );

    disp_scan_ctrl #(.DIV_W(8), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .data_valid(data_valid),
        .blank_mask(blank_mask), .sel(sel1), .sel_en(sel_en1), .digit(digit1),
        .frame_start(fs1)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       sel_en;
        logic [3:0] digit;
        logic       fs;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    // Reference model: time since scan entry, modulo one frame (4*DIV cycles).
    int unsigned divs[2] = '{4, 1};
    int unsigned mt[2];
    bit          mscan[2];
    logic [15:0] msh[2], mpd[2];
    logic        msen[2], mfs[2];

    function automatic exp_t model_step(input int m);
        exp_t        e;
        logic [15:0] load;
        int unsigned d, dig;
        d = divs[m];
        if (rst) begin
            mscan[m] = 0; mt[m] = 0; msh[m] = '0; mpd[m] = '0;
            msen[m] = 0; mfs[m] = 0;
        end else begin
            load = data_valid ? data_in : mpd[m];
            if (!mscan[m]) begin
                mfs[m] = 0; msen[m] = 0;
                if (en) begin
                    mscan[m] = 1; mt[m] = 0; msh[m] = load;
                    mfs[m] = 1; msen[m] = ~blank_mask[0];
                end
            end else if (!en) begin
                mscan[m] = 0; mt[m] = 0; mfs[m] = 0; msen[m] = 0;
            end else begin
                mt[m] = (mt[m] + 1) % (4 * d);
                mfs[m] = 0;
                if (mt[m] % d == 0) begin
                    dig = mt[m] / d;
                    msen[m] = ~blank_mask[dig];
                    if (mt[m] == 0) begin
                        msh[m] = load;
                        mfs[m] = 1;
                    end
                end
            end
            if (data_valid) mpd[m] = data_in;
        end
        dig = mscan[m] ? mt[m] / d : 0;
        e.sel    = 2'(dig);
        e.sel_en = msen[m];
        e.digit  = msh[m][4*dig +: 4];
        e.fs     = mfs[m];
        return e;
    endfunction

    task automatic cycle(input logic r, input logic e, input logic [15:0] d,
                         input logic v, input logic [3:0] b);
        @(negedge clk);
        rst = r; en = e; data_in = d; data_valid = v; blank_mask = b;
        q4.push_back(model_step(0));
        q1.push_back(model_step(1));
    endtask

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual sel=%0d sel_en=%b digit=%h fs=%b required sel=%0d sel_en=%b digit=%h fs=%b",
                     name, $time, act.sel, act.sel_en, act.digit, act.fs,
                     exp.sel, exp.sel_en, exp.digit, exp.fs);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample 1ns after the active edge.
    always begin
        exp_t e, a;
        @(posedge clk);
        #1;
        if (q4.size() != 0) begin
            e = q4.pop_front();
            a = '{sel: sel4, sel_en: sel_en4, digit: digit4, fs: fs4};
            chk("div4", a, e);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            a = '{sel: sel1, sel_en: sel_en1, digit: digit1, fs: fs1};
            chk("div1", a, e);
        end
    end

    logic [15:0] cur_d;
    logic [3:0]  cur_b;
    logic        cur_e;
    bit          found;

    initial begin
        // Reset, then idle with en low.
        repeat (2) cycle(1, 0, 16'h0, 0, 4'h0);
        repeat (5) cycle(0, 0, 16'h0, 0, 4'h0);
        // Load 4321 and start scanning; run past one full frame.
        cycle(0, 0, 16'h4321, 1, 4'h0);
        repeat (22) cycle(0, 1, 16'h0, 0, 4'h0);
        // Mid-frame update: must not tear the current frame.
        cycle(0, 1, 16'hABCD, 1, 4'h0);
        repeat (24) cycle(0, 1, 16'h0, 0, 4'h0);
        // Strobe exactly in the sel 3->0 tick cycle of the DIV=4 instance (bypass path).
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (mscan[0] && mt[0] == 15) found = 1;
            else cycle(0, 1, 16'h0, 0, 4'h0);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL frame_boundary_search actual=not_found required=found");
        end
        cycle(0, 1, 16'h5678, 1, 4'h0);
        repeat (20) cycle(0, 1, 16'h0, 0, 4'h0);
        // Blanking of digit 2, then switch mask mid-dwell.
        repeat (18) cycle(0, 1, 16'h0, 0, 4'b0100);
        repeat (20) cycle(0, 1, 16'h0, 0, 4'b0001);
        // Drop en mid-frame, restart, then reset mid-scan.
        repeat (3) cycle(0, 0, 16'h0, 0, 4'h0);
        repeat (10) cycle(0, 1, 16'h0, 0, 4'h0);
        cycle(1, 1, 16'h0, 0, 4'h0);
        repeat (3) cycle(0, 0, 16'h0, 0, 4'h0);
        // Randomized traffic.
        cur_e = 1; cur_b = '0; cur_d = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) cur_e = ~cur_e;
            if ($urandom_range(0, 29) == 0) cur_b = 4'($urandom);
            cur_d = 16'($urandom);
            cycle(($urandom_range(0, 799) == 0), cur_e, cur_d,
                  ($urandom_range(0, 7) == 0), cur_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (q4.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", q4.size() + q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for a 4-digit display.
- Sits directly upstream of the 2-to-4 digit-select decoder: drives the decoder's 2-bit select and enable inputs, and presents the matching 4-bit digit nibble to the segment encoder.
- Cycles through the digits at a programmable rate.
- Double-buffers the 16-bit display word so a frame never mixes old and new data (no tearing).

Parameters:
- DIV_W, 16, width of the prescaler counter.
- DIV, 50000, clock cycles spent on each digit; legal range 1 .. 2^DIV_W-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  scan enable; low = display dark, scanner idle
- data_in  input  16  display word; digit k = data_in[4k+3:4k]
- data_valid  input  1  one-cycle strobe; captures data_in into pending register
- blank_mask  input  4  bit k set = digit k suppressed (sel_en low while sel==k)
- sel  output  2  digit index to decoder
- sel_en  output  1  decoder enable
- digit  output  4  nibble of shadow word for current sel
- frame_start  output  1  one-cycle pulse when shadow word is (re)loaded

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, cnt=0, sel=0, sel_en=0, frame_start=0.
  - pending=0, shadow=0, so digit=0.
  - Reset has priority over every other input.
- Registers:
  - pending: loads data_in on any cycle with data_valid=1, in either state.
  - shadow: loads only at frame boundaries, per the rules below.
- digit = shadow[4*sel+3 : 4*sel], combinational from registered sel and shadow. No extra latency vs sel.
- FSM states: IDLE, SCAN.
- IDLE:
  - Holds cnt=0, sel=0, sel_en=0, frame_start=0.
  - en=1 at an edge -> SCAN at that edge; same edge: shadow<=load value, frame_start<=1, sel<=0, sel_en<=~blank_mask[0], cnt<=0.
- SCAN:
  - tick = (cnt==DIV-1). Non-tick: cnt<=cnt+1, frame_start<=0.
  - On tick: cnt<=0, sel<=sel+1 (mod 4, 3 wraps to 0), sel_en<=~blank_mask[sel+1].
  - On tick with sel==3: additionally shadow<=load value, frame_start<=1.
  - Digit dwell is exactly DIV cycles; one frame is 4*DIV cycles.
  - en=0 at an edge -> IDLE: sel<=0, sel_en<=0, cnt<=0, frame_start<=0. Shadow is retained.
- Load value, used at every shadow load: data_in if data_valid=1 in that same cycle (bypass), else pending. Pending still captures data_in as normal.
- blank_mask:
  - Sampled only at sel transitions and at SCAN entry.
  - A change mid-dwell takes effect at the next tick.
- DIV=1: tick every cycle; sel advances every cycle; frame_start every 4th cycle.
- en toggled mid-frame: scan restarts at digit 0 with a fresh shadow load on re-entry.
- Outputs are glitch-free: sel, sel_en, frame_start are registered.

Test Plan:
1. DIV=4. rst 2 cycles, then hold en=0 -> sel=0, sel_en=0, digit=0, frame_start=0 every cycle.
2. DIV=4, blank_mask=0. data_in=16'h4321 with data_valid pulse, then en=1 -> frame_start pulses on entry. sel holds 0 (digit=1) for 4 cycles, then 1 (digit=2), 2 (3), 3 (4). frame_start pulses again at cycle 16 as sel wraps to 0. sel_en=1 throughout.
3. DIV=4, scanning 16'h4321. data_valid with 16'hABCD while sel=1 -> remaining digits still 3,4. Next frame shows D,C,B,A. frame_start pulses at the boundary.
4. data_valid with 16'h5678 in the exact cycle of the sel 3->0 tick -> next frame shows 8,7,6,5 (bypass); pending==16'h5678.
5. blank_mask=4'b0100 -> sel_en=0 only for the 4 cycles with sel=2. Set blank_mask=4'b0001 mid-digit-1 -> takes effect at the next sel=0 dwell.
6. en=0 while sel=2 -> next cycle sel=0, sel_en=0. rst asserted mid-SCAN -> all outputs and shadow cleared next edge. DIV=1 -> sel steps every cycle, frame_start every 4 cycles.
